hazard_ctrl: RTL
================

# hazard_ctrl

- Central hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives the per-stage stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers.
- Selects the E-stage operand forwarding sources.
- Runs a data-memory wait FSM that freezes the pipeline while a load or store in M is outstanding, with timeout abort.
- Keeps a saturating count of front-end stall cycles for performance monitoring.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- TIMEOUT, 16, cycle number of an access at which it is aborted; legal range ≥2
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- Rs1D, Rs2D  in  REG_ADDR_W  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  source and destination registers of the instruction in E
- RdM, RdW  in  REG_ADDR_W  destination registers in M and W
- ResultSrcE  in  2  result select in E; 2'b01 = load
- RegWriteM, RegWriteW  in  1  register write enables in M and W
- PCSrcE  in  1  taken branch or jump resolved in E
- MemReqM  in  1  load or store present in M
- MemReadyM  in  1  data memory completes the access this cycle
- ForwardAE, ForwardBE  out  2  operand select: 00 = regfile, 01 = W result, 10 = M ALU result
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (flush W clears RegWriteW and ResultSrcW)
- MemErr  out  1  sticky flag: a memory access was aborted
- StallCount  out  CNT_W  saturating count of cycles with StallF=1

## Operation
Forwarding (combinational, evaluated independently for A/Rs1E and B/Rs2E):
- Select 10 if RegWriteM && RdM!=0 && RdM==RsxE.
- Otherwise select 01 if RegWriteW && RdW!=0 && RdW==RsxE.
- Otherwise select 00.
- The M match wins when M and W both match.

Load-use stall:
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).

Memory wait FSM, states IDLE and WAIT; an access is numbered by cycle k, with k=1 being the first cycle MemReqM is seen in IDLE:
- IDLE, MemReqM && MemReadyM: zero-wait access; no stall; stay in IDLE.
- IDLE, MemReqM && !MemReadyM: memStall=1; go to WAIT; wait counter ← 1.
- WAIT, MemReadyM: memStall=0; go to IDLE.
- WAIT, !MemReadyM, counter < TIMEOUT-1: memStall=1; counter increments.
- WAIT, !MemReadyM, counter == TIMEOUT-1 (cycle k=TIMEOUT): abort. memStall=0, FlushW=1, MemErr ← 1 at the next edge, go to IDLE.
- MemReadyM while in IDLE without MemReqM is ignored.

Output priority, highest first:
1. memStall=1: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. A pending branch or load-use action is deferred; its inputs are held because the stages are stalled.
2. Otherwise:
   - StallF = StallD = lwStall
   - StallE = StallM = 0
   - FlushD = PCSrcE
   - FlushE = lwStall || PCSrcE
   - FlushW = 1 only in the abort cycle
- When PCSrcE and lwStall occur together, the flush wins for D. StallF still holds the PC, but the PC mux takes the branch target because the PC register enable is owned by the fetch logic with PCSrcE priority.

StallCount:
- Increments on every cycle with StallF=1.
- Saturates at all-ones.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, with zero latency.
- FSM state, wait counter, MemErr and StallCount are registered on the clk rising edge.
- Reset values:
  - state IDLE, wait counter 0, MemErr 0, StallCount 0.
  - With all inputs 0 during reset, every output is 0.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately (asynchronous) and memStall drops in the same cycle.
- Maximum pipeline freeze per access is TIMEOUT-1 cycles.
- A new access may start in the cycle right after completion or abort, with no idle cycle required.

## Structure
- Shared package holds:
  - the memory FSM state enum
  - the forward-select constants FWD_RF, FWD_W, FWD_M
  - RESULTSRC_LOAD = 2'b01
- No sub-module. The forwarding compare is instantiated twice as a local function.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. With RdM=0 instead → ForwardAE=01. With Rs2E=0 and RdW=0 → ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly one cycle, and StallCount increments by 1.
- Branch: PCSrcE=1 with no load hazard → FlushD=FlushE=1, all stall outputs 0.
- Memory wait: MemReqM=1, MemReadyM rises on cycle 4 → StallF/D/E/M=1 and FlushW=1 on cycles 1–3; all 0 on cycle 4; state IDLE on cycle 5. Repeat with PCSrcE=1 throughout → FlushD=0 while stalled and FlushD=1 on cycle 4.
- Timeout with TIMEOUT=4 and MemReadyM held 0: stall on cycles 1–3; cycle 4 has stall=0 and FlushW=1; MemErr=1 from cycle 5 and stays set until rst_n.
- Reset during WAIT, and saturation with CNT_W=3:
  - Assert rst_n low in cycle 2 of a wait → stalls drop immediately, MemErr=0, StallCount=0.
  - Hold lwStall for 10 cycles → StallCount stops at 7.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the RV32 hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Forwarding, load-use/branch stall+flush and data-memory wait
//               sequencing for the 5-stage RV32 pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 16,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] Rs1D,
   input  logic [REG_ADDR_W-1:0] Rs2D,
   input  logic [REG_ADDR_W-1:0] Rs1E,
   input  logic [REG_ADDR_W-1:0] Rs2E,
   input  logic [REG_ADDR_W-1:0] RdE,
   input  logic [REG_ADDR_W-1:0] RdM,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic [1:0]            ResultSrcE,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  PCSrcE,
   input  logic                  MemReqM,
   input  logic                  MemReadyM,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushW,
   output logic                  MemErr,
   output logic [CNT_W-1:0]      StallCount
);

   localparam int c_WCNT_W = $clog2(TIMEOUT);
   localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT - 1);
   localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);

   mem_state_t            r_state;
   logic [c_WCNT_W-1:0]   r_wait_cnt;
   logic                  r_mem_err;
   logic [CNT_W-1:0]      r_stall_count;

   logic w_lw_stall;
   logic w_mem_stall;
   logic w_abort;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rd_m,
      input logic                  wr_m,
      input logic [REG_ADDR_W-1:0] rd_w,
      input logic                  wr_w
   );
      if (wr_m && (rd_m != '0) && (rd_m == rs))
         return FWD_M;
      else if (wr_w && (rd_w != '0) && (rd_w == rs))
         return FWD_W;
      else
         return FWD_RF;
   endfunction

   assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
   assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

   assign w_lw_stall = (ResultSrcE == RESULTSRC_LOAD) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

   // rst_n gating keeps a held MemReqM from stalling while reset is asserted
   always_comb begin
      w_mem_stall = 1'b0;
      w_abort     = 1'b0;
      if (rst_n) begin
         case (r_state)
            MEM_IDLE: w_mem_stall = MemReqM && !MemReadyM;
            MEM_WAIT: begin
               if (!MemReadyM) begin
                  if (r_wait_cnt == c_WCNT_LAST)
                     w_abort = 1'b1;
                  else
                     w_mem_stall = 1'b1;
               end
            end
            default: begin
               w_mem_stall = 1'b0;
               w_abort     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= MEM_IDLE;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         case (r_state)
            MEM_IDLE: begin
               if (MemReqM && !MemReadyM) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= c_WCNT_ONE;
               end
            end
            MEM_WAIT: begin
               if (MemReadyM) begin
                  r_state    <= MEM_IDLE;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == c_WCNT_LAST) begin
                  r_state    <= MEM_IDLE;
                  r_wait_cnt <= '0;
                  r_mem_err  <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_WCNT_ONE;
               end
            end
            default: begin
               r_state    <= MEM_IDLE;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   // A memory freeze overrides and defers any branch or load-use action
   assign StallF = w_mem_stall | w_lw_stall;
   assign StallD = w_mem_stall | w_lw_stall;
   assign StallE = w_mem_stall;
   assign StallM = w_mem_stall;
   assign FlushD = !w_mem_stall & PCSrcE;
   assign FlushE = !w_mem_stall & (w_lw_stall | PCSrcE);
   assign FlushW = w_mem_stall | w_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_count <= '0;
      else if (StallF && (r_stall_count != '1))
         r_stall_count <= r_stall_count + CNT_W'(1);
   end

   assign MemErr     = r_mem_err;
   assign StallCount = r_stall_count;

endmodule

`default_nettype wire
